// File: rtl/credit_pkg.sv
// ============================================================================
// credit_pkg : constants and width helpers shared by both ends of the link
// Rev 1.0
// ============================================================================
`default_nettype none

package credit_pkg;

   // The sender's initial credit count must equal the receive depth.
   localparam int unsigned CREDIT_DEPTH = 4;

   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/credit_fifo_rx_mem.sv
// ============================================================================
// credit_fifo_rx_mem : DEPTH x DATA_WIDTH register array, 1 write / 1 async read
// Rev 1.0
// ============================================================================
`default_nettype none

module credit_fifo_rx_mem #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned AW         = 2
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [AW-1:0]         waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]         raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Per-slot decode keeps unused addresses harmless for non power-of-two depths.
   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      always_ff @(posedge clk_i) begin
         if (we_i && (waddr_i == AW'(i))) begin
            mem_q[i] <= wdata_i;
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/credit_fifo_rx.sv
// ============================================================================
// credit_fifo_rx : credit-based receive FIFO, FWFT output, one credit per pop
// Optional overflow detection: define CREDIT_FIFO_RX_OVF_CHECK_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module credit_fifo_rx
   import credit_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = CREDIT_DEPTH
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  in_valid_i,
   input  logic [DATA_WIDTH-1:0] in_data_i,
   output logic                  out_valid_o,
   output logic [DATA_WIDTH-1:0] out_data_o,
   input  logic                  out_ready_i,
   output logic                  credit_return_o,
   output logic                  overflow_o
);

   localparam int unsigned PW = ptr_width(DEPTH);
   localparam int unsigned CW = cnt_width(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          credit_q;
   logic          pop, push, full;

   assign full        = (count_q == CW'(DEPTH));
   assign out_valid_o = (count_q != '0);
   assign pop         = out_valid_o && out_ready_i;
   // A full buffer still accepts a word when the head leaves in the same cycle.
   assign push        = in_valid_i && (!full || pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         credit_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         credit_q <= pop;
      end
   end

   assign credit_return_o = credit_q;

   credit_fifo_rx_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (PW)
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (in_data_i),
      .raddr_i (rd_ptr_q),
      .rdata_o (out_data_o)
   );

`ifdef CREDIT_FIFO_RX_OVF_CHECK_EN
   logic illegal_push;
   logic overflow_q;

   assign illegal_push = in_valid_i && full && !pop;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_q <= 1'b0;
      end else begin
         overflow_q <= overflow_q | illegal_push;
      end
   end

   assign overflow_o = overflow_q;

`ifndef SYNTHESIS
   always @(posedge clk_i) begin
      if (rst_ni && illegal_push) begin
         $error("credit_fifo_rx: push into full buffer, word dropped");
      end
   end
`endif
`else
   assign overflow_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_credit_fifo_rx.sv
// ============================================================================
// tb_credit_fifo_rx : vector table, corner sequences and credit-driven random
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_credit_fifo_rx;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
`ifdef CREDIT_FIFO_RX_OVF_CHECK_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          out_ready = 1'b0;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          credit_ret;
   logic          ovf;

   credit_fifo_rx #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH)
   ) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .in_valid_i      (in_valid),
      .in_data_i       (in_data),
      .out_valid_o     (out_valid),
      .out_data_o      (out_data),
      .out_ready_i     (out_ready),
      .credit_return_o (credit_ret),
      .overflow_o      (ovf)
   );

   always #5 clk = ~clk;

   int            total = 0;
   int            bad   = 0;
   logic [DW-1:0] q[$];
   logic          ovf_m = 1'b0;
   int            pops_m = 0;
   int            pulses = 0;

   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic          r;
      logic          ev;
      logic          cd;
      logic [DW-1:0] ed;
      logic          ec;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   // Drive one cycle from posedge+1, predict from the queue model, check at next posedge+1.
   task automatic apply(input logic v, input logic [DW-1:0] d, input logic r);
      bit pop, push;
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      pop  = (q.size() != 0) && r;
      push = v && ((q.size() < DEPTH) || pop);
      if (pop) begin
         void'(q.pop_front());
         pops_m++;
      end
      if (push) q.push_back(d);
      if (v && !push && OVF_EN) ovf_m = 1'b1;
      @(posedge clk);
      #1;
      if (credit_ret) pulses++;
      chk("valid", out_valid, q.size() != 0);
      if (q.size() != 0) chk("data", out_data, q[0]);
      chk("credit", credit_ret, pop);
      chk("overflow", ovf, ovf_m);
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_credit", credit_ret, 0);
      chk("rst_overflow", ovf, 0);
      q.delete();
      ovf_m = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_valid", out_valid, 0);
      chk("post_rst_credit", credit_ret, 0);
   endtask

   function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic r,
                               input logic ev, input logic cd, input logic [DW-1:0] ed,
                               input logic ec);
      vec_t t;
      t.v = v; t.d = d; t.r = r; t.ev = ev; t.cd = cd; t.ed = ed; t.ec = ec;
      return t;
   endfunction

   initial begin
      logic [DW-1:0] got[$];
      int            seen99;
      int            credits;
      bit            v;

      tbl[0]  = mk(1, 8'hA1, 0, 1, 1, 8'hA1, 0);
      tbl[1]  = mk(1, 8'hB2, 0, 1, 1, 8'hA1, 0);
      tbl[2]  = mk(1, 8'hC3, 0, 1, 1, 8'hA1, 0);
      tbl[3]  = mk(0, 8'h00, 1, 1, 1, 8'hB2, 1);
      tbl[4]  = mk(0, 8'h00, 1, 1, 1, 8'hC3, 1);
      tbl[5]  = mk(0, 8'h00, 1, 0, 0, 8'h00, 1);
      tbl[6]  = mk(0, 8'h00, 0, 0, 0, 8'h00, 0);
      tbl[7]  = mk(1, 8'h10, 0, 1, 1, 8'h10, 0);
      tbl[8]  = mk(1, 8'h11, 0, 1, 1, 8'h10, 0);
      tbl[9]  = mk(1, 8'h12, 0, 1, 1, 8'h10, 0);
      tbl[10] = mk(1, 8'h13, 0, 1, 1, 8'h10, 0);
      tbl[11] = mk(0, 8'h00, 1, 1, 1, 8'h11, 1);
      tbl[12] = mk(0, 8'h00, 1, 1, 1, 8'h12, 1);
      tbl[13] = mk(0, 8'h00, 1, 1, 1, 8'h13, 1);
      tbl[14] = mk(0, 8'h00, 1, 0, 0, 8'h00, 1);
      tbl[15] = mk(0, 8'h00, 0, 0, 0, 8'h00, 0);

      do_reset();

      for (int i = 0; i < 16; i++) begin
         apply(tbl[i].v, tbl[i].d, tbl[i].r);
         chk($sformatf("tbl%0d_valid", i), out_valid, tbl[i].ev);
         if (tbl[i].cd) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
         chk($sformatf("tbl%0d_credit", i), credit_ret, tbl[i].ec);
      end

      // Full buffer with simultaneous push and pop.
      for (int i = 0; i < DEPTH; i++) apply(1, 8'(8'h20 + i), 0);
      apply(1, 8'h55, 1);
      chk("fullpp_credit", credit_ret, 1);
      chk("fullpp_ovf", ovf, 0);
      got.delete();
      for (int k = 0; k < 8; k++) begin
         if (out_valid) got.push_back(out_data);
         apply(0, 8'h00, 1);
      end
      chk("fullpp_words", got.size(), 4);
      if (got.size() == 4) begin
         chk("fullpp_first", got[0], 8'h21);
         chk("fullpp_fifth", got[3], 8'h55);
      end

      // Illegal push into a full buffer.
      for (int i = 0; i < DEPTH; i++) apply(1, 8'(8'h30 + i), 0);
      apply(1, 8'h99, 0);
      chk("illegal_ovf", ovf, OVF_EN);
      apply(0, 8'h00, 0);
      chk("illegal_ovf_hold", ovf, OVF_EN);
      got.delete();
      seen99 = 0;
      for (int k = 0; k < 8; k++) begin
         if (out_valid) begin
            got.push_back(out_data);
            if (out_data == 8'h99) seen99++;
         end
         apply(0, 8'h00, 1);
      end
      chk("illegal_words", got.size(), 4);
      chk("illegal_no_99", seen99, 0);
      do_reset();

      // Continuous streaming across pointer wrap.
      pulses = 0;
      pops_m = 0;
      apply(1, 8'h40, 0);
      for (int i = 0; i < 3 * DEPTH; i++) apply(1, 8'(8'h41 + i), 1);
      for (int k = 0; k < 3; k++) apply(0, 8'h00, 1);
      chk("stream_pulses", pulses, 3 * DEPTH + 1);
      chk("stream_pops", pops_m, 3 * DEPTH + 1);

      // Asynchronous reset mid-stream with a pulse in flight.
      for (int i = 0; i < 3; i++) apply(1, 8'(8'h60 + i), 0);
      apply(0, 8'h00, 1);
      chk("midrst_pre_credit", credit_ret, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_credit", credit_ret, 0);
      chk("midrst_ovf", ovf, 0);
      q.delete();
      ovf_m = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) apply(0, 8'h00, 1);

      // Random traffic from a credit-respecting sender.
      do_reset();
      pulses  = 0;
      pops_m  = 0;
      credits = DEPTH;
      for (int n = 0; n < 400; n++) begin
         v = (credits > 0) && ($urandom_range(0, 3) != 0);
         if (v) credits--;
         apply(v, 8'($urandom), 1'($urandom_range(0, 1)));
         if (credit_ret) credits++;
      end
      for (int k = 0; k < 10; k++) begin
         apply(0, 8'h00, 1);
         if (credit_ret) credits++;
      end
      chk("rand_credits", credits, DEPTH);
      chk("rand_pulses", pulses, pops_m);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
